// File: rtl/mem_apb_master_bridge_pkg.sv
// Shared types for the data-side memory/APB bridge: FSM states, decode results
// and the latched APB request.
package mem_apb_pkg;

    localparam int REQ_AW = 32;
    localparam int REQ_DW = 32;
    localparam int REQ_SW = REQ_DW / 8;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    typedef enum logic [1:0] {
        DEC_OCM = 2'd0,
        DEC_SLV = 2'd1,
        DEC_ERR = 2'd2
    } dec_res_e;

    typedef struct packed {
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
        logic [REQ_SW-1:0] strb;
        logic              write;
        logic [SEL_W-1:0]  sel;
    } apb_req_t;

    function automatic logic [15:0] sel_onehot(input logic [SEL_W-1:0] idx);
        sel_onehot = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/mem_apb_master_bridge_if.sv
// APB master-side bus bundle with one select/ready/error/read-data lane per slave.
interface mem_apb_master_bridge_if #(
    parameter int N_SLAVES = 4,
    parameter int APB_AW   = 32,
    parameter int APB_DW   = 32
);
    logic [APB_AW-1:0]          paddr;
    logic [N_SLAVES-1:0]        psel;
    logic                       penable;
    logic                       pwrite;
    logic [APB_DW-1:0]          pwdata;
    logic [APB_DW/8-1:0]        pstrb;
    logic [N_SLAVES*APB_DW-1:0] prdata;
    logic [N_SLAVES-1:0]        pready;
    logic [N_SLAVES-1:0]        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/mem_apb_master_bridge_apb_addr_decoder.sv
// Window decoder: OCM window first, then slave windows with the lowest index
// winning on overlap; anything else is a decode error.
module apb_addr_decoder
    import mem_apb_pkg::*;
#(
    parameter int                       XLEN     = 32,
    parameter int                       N_SLAVES = 4,
    parameter logic [XLEN-1:0]          OCM_BASE = 32'h0000_0000,
    parameter logic [XLEN-1:0]          OCM_SIZE = 32'h0001_0000,
    parameter logic [N_SLAVES*XLEN-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*XLEN-1:0] SLV_SIZE = '0,
    parameter int                       IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic [XLEN-1:0]  addr_i,
    output dec_res_e         res_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [XLEN-1:0]  offset_o
);

    // Windows are power-of-two sized and aligned, so a masked compare suffices.
    function automatic logic win_hit(input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] base,
                                     input logic [XLEN-1:0] size);
        win_hit = ((a & ~(size - XLEN'(1))) == base);
    endfunction

    // Priority decode; scanning high-to-low leaves the lowest hitting index.
    always_comb begin
        res_o    = DEC_ERR;
        idx_o    = '0;
        offset_o = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            res_o    = win_hit(addr_i, SLV_BASE[i*XLEN +: XLEN], SLV_SIZE[i*XLEN +: XLEN]) ? DEC_SLV : res_o;
            idx_o    = win_hit(addr_i, SLV_BASE[i*XLEN +: XLEN], SLV_SIZE[i*XLEN +: XLEN]) ? IDX_W'(i) : idx_o;
            offset_o = win_hit(addr_i, SLV_BASE[i*XLEN +: XLEN], SLV_SIZE[i*XLEN +: XLEN])
                       ? (addr_i - SLV_BASE[i*XLEN +: XLEN]) : offset_o;
        end
        if (win_hit(addr_i, OCM_BASE, OCM_SIZE)) begin
            res_o    = DEC_OCM;
            offset_o = addr_i - OCM_BASE;
        end else begin
            res_o    = res_o;
        end
    end

endmodule

// File: rtl/mem_apb_master_bridge.sv
// Core data-port bridge: OCM window goes straight to the dcache, slave windows
// are served by an APB master FSM that stalls the core until completion.
module mem_apb_master_bridge
    import mem_apb_pkg::*;
#(
    parameter int                       XLEN     = 32,
    parameter int                       APB_AW   = 32,
    parameter int                       APB_DW   = 32,
    parameter int                       N_SLAVES = 4,
    parameter logic [XLEN-1:0]          OCM_BASE = 32'h0000_0000,
    parameter logic [XLEN-1:0]          OCM_SIZE = 32'h0001_0000,
    parameter logic [N_SLAVES*XLEN-1:0] SLV_BASE = {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000},
    parameter logic [N_SLAVES*XLEN-1:0] SLV_SIZE = {4{32'h0000_1000}},
    parameter int                       TIMEOUT  = 255
) (
    input  logic                core_clk_i,
    input  logic                core_reset_i,
    input  logic [XLEN-1:0]     mem_addr_i,
    input  logic                mem_read_en_i,
    input  logic                mem_write_en_i,
    input  logic [XLEN-1:0]     mem_write_data_i,
    input  logic [XLEN/8-1:0]   mem_wstrb_i,
    output logic [XLEN-1:0]     mem_read_data_o,
    output logic                mem_ready_o,
    output logic                mem_err_o,
    output logic [XLEN-1:0]     dcache_addr_o,
    output logic                dcache_read_en_o,
    output logic                dcache_write_en_o,
    output logic [XLEN-1:0]     dcache_write_data_o,
    input  logic [XLEN-1:0]     dcache_read_data_i,
    mem_apb_master_bridge_if.master m_apb
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int SW    = APB_DW / 8;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    apb_state_e       state_q, state_d;
    apb_req_t         req_q, req_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             ocm_rd_q;

    dec_res_e         dec_res_s;
    logic [IDX_W-1:0] dec_idx_s;
    logic [XLEN-1:0]  dec_off_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             req_s;
    logic             ocm_go_s;
    logic             sel_ready_s;
    logic             sel_slverr_s;
    logic [APB_DW-1:0] sel_prdata_s;

    apb_addr_decoder #(
        .XLEN     (XLEN),
        .N_SLAVES (N_SLAVES),
        .OCM_BASE (OCM_BASE),
        .OCM_SIZE (OCM_SIZE),
        .SLV_BASE (SLV_BASE),
        .SLV_SIZE (SLV_SIZE),
        .IDX_W    (IDX_W)
    ) u_dec (
        .addr_i   (mem_addr_i),
        .res_o    (dec_res_s),
        .idx_o    (dec_idx_s),
        .offset_o (dec_off_s)
    );

    assign req_s        = mem_read_en_i | mem_write_en_i;
    assign ocm_go_s     = (state_q == ST_IDLE) && req_s && (dec_res_s == DEC_OCM);
    assign sel_idx_s    = IDX_W'(req_q.sel);
    assign sel_ready_s  = m_apb.pready[sel_idx_s];
    assign sel_slverr_s = m_apb.pslverr[sel_idx_s];
    assign sel_prdata_s = m_apb.prdata[sel_idx_s*APB_DW +: APB_DW];

    // OCM requests pass straight through; the cache sees zeros otherwise.
    assign dcache_addr_o       = ocm_go_s ? mem_addr_i : '0;
    assign dcache_read_en_o    = ocm_go_s & mem_read_en_i & ~mem_write_en_i;
    assign dcache_write_en_o   = ocm_go_s & mem_write_en_i;
    assign dcache_write_data_o = (ocm_go_s & mem_write_en_i) ? mem_write_data_i : '0;

    assign m_apb.paddr   = APB_AW'(req_q.addr);
    assign m_apb.pwrite  = req_q.write;
    assign m_apb.pwdata  = APB_DW'(req_q.wdata);
    assign m_apb.pstrb   = SW'(req_q.strb);
    assign m_apb.penable = (state_q == ST_ACCESS);
    assign m_apb.psel    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS))
                           ? N_SLAVES'(sel_onehot(req_q.sel)) : '0;

    assign mem_ready_o     = ocm_go_s | (state_q == ST_DONE);
    assign mem_err_o       = (state_q == ST_DONE) & err_q;
    assign mem_read_data_o = ocm_rd_q ? dcache_read_data_i
                           : ((state_q == ST_DONE) ? rdata_q : '0);

    // APB transfer sequencing: next state, latched request, timer and result.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && (dec_res_s == DEC_SLV)) begin
                    req_d.addr  = REQ_AW'(dec_off_s);
                    req_d.wdata = REQ_DW'(mem_write_data_i);
                    req_d.strb  = mem_write_en_i ? REQ_SW'(mem_wstrb_i) : '1;
                    req_d.write = mem_write_en_i;
                    req_d.sel   = SEL_W'(dec_idx_s);
                    timer_d     = '0;
                    state_d     = ST_SETUP;
                end else if (req_s && (dec_res_s == DEC_ERR)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready_s) begin
                    rdata_d = (req_q.write || sel_slverr_s) ? '0 : XLEN'(sel_prdata_s);
                    err_d   = sel_slverr_s;
                    state_d = ST_DONE;
                end else if (timer_q == TMAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge core_clk_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            timer_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ocm_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            timer_q  <= timer_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ocm_rd_q <= ocm_go_s & mem_read_en_i & ~mem_write_en_i;
        end
    end

endmodule

// File: tb/tb_mem_apb_master_bridge.sv
// Randomised bench for mem_apb_master_bridge: a transaction-level model predicts
// every output per cycle from the address map and the APB timing rules.
module tb_mem_apb_master_bridge;

    localparam int NS  = 4;
    localparam int TMO = 8;
    localparam logic [31:0] OCM_B  = 32'h0000_0000;
    localparam logic [31:0] OCM_S  = 32'h0001_0000;
    localparam logic [31:0] SLV_B0 = 32'h1000_0000;
    localparam logic [31:0] SLV_S  = 32'h0000_1000;
    localparam int K_OCM = 0, K_SLV = 1, K_ERR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wd, dc_rdata;
    logic        mem_re, mem_we;
    logic [3:0]  mem_ws;
    logic [31:0] mem_read_data_o, dcache_addr_o, dcache_write_data_o;
    logic        mem_ready_o, mem_err_o, dcache_read_en_o, dcache_write_en_o;

    mem_apb_master_bridge_if #(.N_SLAVES(NS), .APB_AW(32), .APB_DW(32)) bus ();

    mem_apb_master_bridge #(
        .XLEN(32), .APB_AW(32), .APB_DW(32), .N_SLAVES(NS),
        .OCM_BASE(OCM_B), .OCM_SIZE(OCM_S),
        .SLV_BASE({32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000}),
        .SLV_SIZE({4{SLV_S}}),
        .TIMEOUT(TMO)
    ) dut (
        .core_clk_i          (clk),
        .core_reset_i        (rst),
        .mem_addr_i          (mem_addr),
        .mem_read_en_i       (mem_re),
        .mem_write_en_i      (mem_we),
        .mem_write_data_i    (mem_wd),
        .mem_wstrb_i         (mem_ws),
        .mem_read_data_o     (mem_read_data_o),
        .mem_ready_o         (mem_ready_o),
        .mem_err_o           (mem_err_o),
        .dcache_addr_o       (dcache_addr_o),
        .dcache_read_en_o    (dcache_read_en_o),
        .dcache_write_en_o   (dcache_write_en_o),
        .dcache_write_data_o (dcache_write_data_o),
        .dcache_read_data_i  (dc_rdata),
        .m_apb               (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
    endfunction

    // Expected outputs for the current cycle, filled in by the driver.
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_err, exp_pen, apb_chk, exp_pwrite, exp_dc_re, exp_dc_we;
    logic [3:0]  exp_psel, exp_pstrb;
    logic [31:0] exp_rdata, exp_paddr, exp_pwdata, exp_dc_addr, exp_dc_wd;
    logic        ocm_rd_prev = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            chk("ready", 32'(mem_ready_o), 32'(exp_ready));
            if (exp_ready) chk("err", 32'(mem_err_o), 32'(exp_err));
            chk("rdata", mem_read_data_o, exp_rdata);
            chk("psel", 32'(bus.psel), 32'(exp_psel));
            chk("penable", 32'(bus.penable), 32'(exp_pen));
            if (apb_chk) begin
                chk("paddr", bus.paddr, exp_paddr);
                chk("pwrite", 32'(bus.pwrite), 32'(exp_pwrite));
                chk("pstrb", 32'(bus.pstrb), 32'(exp_pstrb));
                if (exp_pwrite) chk("pwdata", bus.pwdata, exp_pwdata);
            end
            chk("dc_addr", dcache_addr_o, exp_dc_addr);
            chk("dc_re", 32'(dcache_read_en_o), 32'(exp_dc_re));
            chk("dc_we", 32'(dcache_write_en_o), 32'(exp_dc_we));
            chk("dc_wd", dcache_write_data_o, exp_dc_wd);
        end
    end

    // Address map by plain range arithmetic: OCM, then slaves lowest first.
    function automatic void model_decode(input logic [31:0] a, output int kind,
                                         output int idx, output logic [31:0] off);
        kind = K_ERR; idx = 0; off = 32'h0;
        if (a >= OCM_B && (a - OCM_B) < OCM_S) begin
            kind = K_OCM;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (kind == K_ERR && a >= SLV_B0 + i * SLV_S && (a - (SLV_B0 + i * SLV_S)) < SLV_S) begin
                    kind = K_SLV; idx = i; off = a - (SLV_B0 + i * SLV_S);
                end
            end
        end
    endfunction

    task automatic rand_slaves();
        bus.prdata  = {$urandom, $urandom, $urandom, $urandom};
        bus.pready  = 4'($urandom);
        bus.pslverr = 4'($urandom);
    endtask

    task automatic clear_exp();
        exp_ready = 1'b0; exp_err = 1'b0; exp_psel = 4'h0; exp_pen = 1'b0; apb_chk = 1'b0;
        exp_dc_addr = 32'h0; exp_dc_re = 1'b0; exp_dc_we = 1'b0; exp_dc_wd = 32'h0;
    endtask

    int          r_k;
    logic [31:0] r_data, r_paddr;
    logic        r_err;
    logic [3:0]  r_psel, r_pstrb;

    // One core request held until ready; w = PREADY wait cycles (w > TMO never answers).
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic rd,
                           input logic [31:0] wd, input logic [3:0] ws, input int w,
                           input logic slverr, input logic [31:0] pdat);
        int kind, idx, a, last;
        logic [31:0] off;
        logic tmo;
        model_decode(addr, kind, idx, off);
        tmo  = (w > TMO);
        a    = tmo ? TMO : w;
        last = (kind == K_OCM) ? 0 : ((kind == K_ERR) ? 1 : 3 + a);
        r_k = -1; r_data = 32'h0; r_err = 1'b0; r_paddr = 32'h0; r_psel = 4'h0; r_pstrb = 4'h0;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            mem_addr = addr; mem_we = wr; mem_re = rd; mem_wd = wd; mem_ws = ws;
            dc_rdata = $urandom;
            rand_slaves();
            if (kind == K_SLV) begin
                if (k == 2 + w) begin
                    bus.pready[idx]  = 1'b1;
                    bus.pslverr[idx] = slverr;
                    bus.prdata[idx*32 +: 32] = pdat;
                end else begin
                    bus.pready[idx] = 1'b0;
                end
            end
            clear_exp();
            exp_rdata  = ocm_rd_prev ? dc_rdata : 32'h0;
            exp_paddr  = off;
            exp_pwrite = wr;
            exp_pstrb  = wr ? ws : 4'hF;
            exp_pwdata = wd;
            if (kind == K_OCM) begin
                exp_ready = 1'b1; exp_err = 1'b0;
                exp_dc_addr = addr; exp_dc_we = wr; exp_dc_re = rd & ~wr;
                exp_dc_wd = wr ? wd : 32'h0;
            end else if (k == last) begin
                exp_ready = 1'b1;
                exp_err   = (kind == K_ERR) || tmo || slverr;
                exp_rdata = (kind == K_SLV && rd && !wr && !tmo && !slverr) ? pdat : 32'h0;
            end else if (kind == K_SLV && k >= 1) begin
                exp_psel = 4'b0001 << idx; exp_pen = (k >= 2); apb_chk = 1'b1;
            end
            ocm_rd_prev = (kind == K_OCM) && rd && !wr;
            #3;
            if (mem_ready_o && r_k < 0) begin
                r_k = k; r_data = mem_read_data_o; r_err = mem_err_o;
            end
            if (k == 1) begin
                r_paddr = bus.paddr; r_psel = bus.psel; r_pstrb = bus.pstrb;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_we = 1'b0; mem_re = 1'b0; mem_addr = $urandom; dc_rdata = $urandom;
        rand_slaves();
        clear_exp();
        exp_rdata = ocm_rd_prev ? dc_rdata : 32'h0;
        ocm_rd_prev = 1'b0;
    endtask

    int          sel, rw, wt;
    logic [31:0] taddr;

    initial begin
        rst = 1'b1; mem_addr = 32'h0; mem_we = 1'b0; mem_re = 1'b0; mem_wd = 32'h0;
        mem_ws = 4'h0; dc_rdata = 32'h0;
        bus.prdata = '0; bus.pready = '0; bus.pslverr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #3;
        chk("rst_ready", 32'(mem_ready_o), 32'd0);
        chk("rst_err", 32'(mem_err_o), 32'd0);
        chk("rst_rdata", mem_read_data_o, 32'd0);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        chk("rst_pen", 32'(bus.penable), 32'd0);
        chk("rst_paddr", bus.paddr, 32'd0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
        chk("rst_pwdata", bus.pwdata, 32'd0);
        chk("rst_pstrb", 32'(bus.pstrb), 32'd0);
        @(negedge clk); rst = 1'b0;
        chk_en = 1'b1;

        run_txn(OCM_B + 32'h10, 1'b1, 1'b0, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0);
        chk("ocm_wr_lat", 32'(r_k), 32'd0);
        run_txn(OCM_B + 32'h10, 1'b0, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        chk("ocm_rd_lat", 32'(r_k), 32'd0);
        run_txn(32'h1000_1004, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, 32'h0);
        chk("s1_wr_lat", 32'(r_k), 32'd3);
        chk("s1_wr_err", 32'(r_err), 32'd0);
        chk("s1_paddr", r_paddr, 32'h4);
        chk("s1_psel", 32'(r_psel), 32'h2);
        chk("s1_pstrb", 32'(r_pstrb), 32'h3);
        run_txn(32'h1000_2008, 1'b0, 1'b1, 32'h0, 4'h0, 5, 1'b0, 32'h1234_5678);
        chk("s2_rd_lat", 32'(r_k), 32'd8);
        chk("s2_rd_data", r_data, 32'h1234_5678);
        run_txn(32'h1000_0020, 1'b0, 1'b1, 32'h0, 4'h0, 1, 1'b1, 32'hCAFE_F00D);
        chk("s0_slverr", 32'(r_err), 32'd1);
        chk("s0_data", r_data, 32'h0);
        run_txn(32'h2000_0000, 1'b0, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        chk("dec_lat", 32'(r_k), 32'd1);
        chk("dec_err", 32'(r_err), 32'd1);
        chk("dec_psel", 32'(r_psel), 32'd0);
        run_txn(32'h1000_3000, 1'b0, 1'b1, 32'h0, 4'h0, 100, 1'b0, 32'h0);
        chk("tmo_lat", 32'(r_k), 32'd11);
        chk("tmo_err", 32'(r_err), 32'd1);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0) taddr = OCM_B + 32'($urandom_range(0, 16383)) * 32'd4;
            else if (sel == 5) taddr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            else taddr = SLV_B0 + 32'(sel - 1) * SLV_S + 32'($urandom_range(0, 1023)) * 32'd4;
            rw = $urandom_range(0, 2);
            wt = $urandom_range(0, TMO + 2);
            run_txn(taddr, rw != 1 ? 1'b0 : 1'b1, rw != 0 && rw != 1 ? 1'b1 : (rw == 0),
                    $urandom, 4'($urandom), wt, $urandom_range(0, 3) == 0, $urandom);
            if (rw == 2) begin
                run_txn(taddr, 1'b1, 1'b1, $urandom, 4'($urandom), wt, 1'b0, $urandom);
            end
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset while slave 3 sits in ACCESS: bus must drop without a clock edge.
        idle_cycle();
        @(negedge clk);
        mem_addr = 32'h1000_3010; mem_re = 1'b1; mem_we = 1'b0;
        bus.pready = 4'h0; bus.pslverr = 4'h0;
        chk_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_pen_pre", 32'(bus.penable), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_psel", 32'(bus.psel), 32'd0);
        chk("mid_rst_pen", 32'(bus.penable), 32'd0);
        chk("mid_rst_paddr", bus.paddr, 32'd0);
        chk("mid_rst_ready", 32'(mem_ready_o), 32'd0);
        mem_re = 1'b0;
        @(negedge clk); rst = 1'b0; ocm_rd_prev = 1'b0;
        repeat (3) begin
            @(negedge clk); #3;
            chk("post_rst_ready", 32'(mem_ready_o), 32'd0);
        end
        chk_en = 1'b1;
        run_txn(32'h1000_1100, 1'b0, 1'b1, 32'h0, 4'h0, 2, 1'b0, 32'h5A5A_1234);
        chk("post_rst_data", r_data, 32'h5A5A_1234);
        run_txn(OCM_B + 32'h40, 1'b0, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        idle_cycle();
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
